// File: rtl/div_pkg.sv
// Shared constants for the ALU-control / divider handshake: function codes,
// divider state encoding and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [5:0] DIVU    = 6'b011011;
  localparam logic [5:0] MFHI    = 6'b010000;
  localparam logic [5:0] MFLO    = 6'b010010;
  localparam logic [5:0] HILO_WR = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO architectural register pair plus the MFHI/MFLO read mux feeding the
// datapath result bus.
module hilo_reg
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [5:0]       i_ctrl,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_we) begin
      r_hi <= i_hi;
      r_lo <= i_lo;
    end
  end

  always_comb begin
    o_dout = '0;
    case (i_ctrl)
      MFHI:    o_dout = r_hi;
      MFLO:    o_dout = r_lo;
      default: o_dout = '0;
    endcase
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/div_hilo_unit.sv
// Sequential unsigned restoring divider feeding the HI/LO pair.
// Optional build macro DIV_ZERO_CHECK_EN adds the sticky dz flag and blocks commit on divide-by-zero.
module div_hilo_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       ctrl,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
`ifdef DIV_ZERO_CHECK_EN
  output logic             dz,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_busy;

  // The shifted remainder keeps its carry bit so divisors above 2^(WIDTH-1)
  // still compare correctly.
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_hilo_we;

  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_sub     = w_rem_sh[WIDTH-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

`ifdef DIV_ZERO_CHECK_EN
  logic r_dz;
  assign w_hilo_we = (r_state == DONE) && (ctrl == HILO_WR) && !r_dz;
  assign dz        = r_dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dz <= 1'b0;
    end else if (r_state == IDLE && ctrl == DIVU) begin
      r_dz <= (dataB == '0);
    end
  end
`else
  assign w_hilo_we = (r_state == DONE) && (ctrl == HILO_WR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ctrl == DIVU) begin
            r_rem   <= '0;
            r_quo   <= dataA;
            r_dvs   <= dataB;
            r_cnt   <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (ctrl == DIVU) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          // DIVU holds the result; any other code (commit or not) releases it.
          if (ctrl != DIVU) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_hilo_we),
    .i_ctrl (ctrl),
    .i_hi   (r_rem),
    .i_lo   (r_quo),
    .o_hi   (hi),
    .o_lo   (lo),
    .o_dout (dout)
  );

  assign busy      = r_busy;
  assign state_dbg = r_state;

endmodule

// File: doc/div_hilo_unit.md
# div_hilo_unit

Sequential 32-bit unsigned divider with the HI/LO register pair. It is the consumer of the 6-bit function code that the ALU control block drives on its divider output. On DIVU it runs a 32-iteration restoring shift-subtract division. When the control block issues the HI/LO-open code (6'b111111), it commits the remainder to HI and the quotient to LO. MFHI/MFLO read the pair back to the datapath result mux.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- ctrl  input  6  function code from ALU control: DIVU=6'b011011, MFHI=6'b010000, MFLO=6'b010010, HILO_WR=6'b111111; all other codes are "other".
- dataA  input  WIDTH  dividend; sampled only at start.
- dataB  input  WIDTH  divisor; sampled only at start.
- dout  output  WIDTH  HI when ctrl==MFHI, LO when ctrl==MFLO, otherwise 0. Combinational from the registers.
- hi  output  WIDTH  HI register (remainder).
- lo  output  WIDTH  LO register (quotient).
- busy  output  1  high while state is RUN.
- dz  output  1  present only with DIV_ZERO_CHECK_EN: divisor was zero at start; sticky until the next start.

## Operation
- States:
  - IDLE: waits for a start.
  - RUN: performs the division; a 6-bit counter cnt tracks iterations.
  - DONE: result ready, waiting for commit.
- IDLE -> RUN: on an edge with ctrl==DIVU.
  - Loads rem=0, quo=dataA, dvs=dataB, cnt=0.
- RUN, each edge with ctrl==DIVU, one iteration:
  - Shift {rem,quo} left by 1.
  - Compute the 33-bit diff = {1'b0,rem_shifted} - {1'b0,dvs}.
  - If diff[32]==0: rem=diff[31:0] and quo[0]=1.
  - cnt++. When cnt reaches WIDTH-1 on that edge, go to DONE.
- RUN with ctrl != DIVU (including HILO_WR): abort to IDLE. HI/LO are unchanged.
- DONE:
  - ctrl==DIVU: hold in DONE; no restart.
  - ctrl==HILO_WR: HI<=rem, LO<=quo, go to IDLE.
  - Any other code: go to IDLE without writing.
- HILO_WR in IDLE is ignored.
- Divide by zero without the macro falls out of the algorithm naturally: quo=all ones, rem=dividend.
- MFHI/MFLO never change state. They may be read in any state and return the last committed values.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, cnt=0.
  - rem, quo, dvs, hi, lo = 0.
  - busy=0, dz=0. dout follows the decode of the reset HI/LO values (0).
- Reset asserted mid-RUN or in DONE discards the operation; no HI/LO write occurs.
- Latency:
  - Start edge E0.
  - Iterations on edges E1..E32; DONE is entered after E32.
  - The earliest commit is edge E33, which matches ALU control emitting HILO_WR on its 33rd DIVU clock.
  - New HI/LO are visible on hi/lo/dout from just after the commit edge.
- busy rises after E0 and falls after E32.
- A DIVU present on the edge immediately after the commit starts a new division (back-to-back, no gap).
- Simultaneous events resolve by state. The same code means different things in different states: HILO_WR aborts in RUN and commits in DONE.

## Configuration
- DIV_ZERO_CHECK_EN defined:
  - dz port exists and is set at start when dataB==0.
  - In DONE, HILO_WR with dz=1 leaves HI/LO unchanged and returns to IDLE.
  - Iteration timing is identical in both builds.
- Undefined:
  - No dz port.
  - Divide by zero commits quo=all ones and rem=dividend.

## Structure
- Shared package div_pkg holds:
  - Function-code constants DIVU, MFHI, MFLO, HILO_WR.
  - The state enum (IDLE, RUN, DONE).
  - Default WIDTH.
- The ALU control block uses the same constants from div_pkg.
- One sub-module, hilo_reg, contains:
  - The HI/LO register pair with write enable and asynchronous active-low reset.
  - The MFHI/MFLO read mux that drives dout.
- The FSM and datapath stay in div_hilo_unit.

## Test plan
- 100/7: DIVU for 33 edges, then HILO_WR -> lo=14, hi=2. busy is high for exactly 32 cycles.
- 0xFFFFFFFF/1 back-to-back with 0x80000000/0x10000 -> lo=0xFFFFFFFF, hi=0, then lo=0x8000, hi=0. The second start falls on the edge right after the first commit.
- 12345/0:
  - Without the macro: lo=0xFFFFFFFF, hi=12345.
  - With the macro: dz=1 and hi/lo keep the prior values.
- Abort: 50/3, ctrl switches to ADD (6'b100000) after 10 iterations -> IDLE, busy=0, hi/lo unchanged. A subsequent HILO_WR is ignored.
- rst_n pulsed low asynchronously mid-RUN at iteration 20 -> immediate IDLE, all registers 0. A later 9/4 then yields lo=2, hi=1.
- After 100/7 commits: ctrl=MFHI -> dout=2; ctrl=MFLO -> dout=14; ctrl=OR -> dout=0. None of these changes state.
